flog_i2f: RTL and testbench

Output stage of the bfloat16 logarithm unit: takes the signed fixed-point log2 result produced by the Philo stage (DIM = 22 bits, COMMA_POS = 14 fractional bits) together with the special-case flags of the original operand, and returns the bfloat16 result. Normalisation is iterative, one bit per cycle, followed by a round-to-nearest-even step. Valid/ready handshakes are used on both sides.

---
 rtl/flog_pkg.sv | 60 ++++++
 rtl/flog_rne.sv | 32 +++
 rtl/flog_i2f.sv | 106 ++++++++++
 tb/tb_flog_i2f.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flog_pkg.sv
// flog_pkg: shared constants, types and helpers for the bfloat16 log2 output stage.
//   DIM/COMMA_POS describe the fixed-point log2 input, BIAS is the bfloat16 exponent bias.
//   special_decode() applies the special-case priority to a captured operand.
package flog_pkg;

   localparam int unsigned DIM       = 22;
   localparam int unsigned COMMA_POS = 14;
   localparam int unsigned BIAS      = 127;

   // Exponent of a value whose leading one sits at mag[DIM-1] with zero shifts.
   localparam int unsigned EXP_BASE  = BIAS + (DIM - 1) - COMMA_POS;

   localparam logic [15:0] QNAN_BF16      = 16'h7FC0;
   localparam logic [15:0] PLUS_INF_BF16  = 16'h7F80;
   localparam logic [15:0] MINUS_INF_BF16 = 16'hFF80;
   localparam logic [15:0] PLUS_ZERO_BF16 = 16'h0000;

   // special_i bit positions
   localparam int unsigned SP_IS_OP_VALID = 0;
   localparam int unsigned SP_IS_NAN      = 1;
   localparam int unsigned SP_IS_SNAN     = 2;
   localparam int unsigned SP_IS_QNAN     = 3;
   localparam int unsigned SP_IS_POS_ZERO = 4;
   localparam int unsigned SP_IS_POS_INF  = 5;
   localparam int unsigned SP_IS_NEG      = 6;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      DONE
   } flog_i2f_state_t;

   typedef struct packed {
      logic        hit;
      logic [15:0] value;
   } flog_special_t;

   // Operand validity does not alter the result; only the exception flags and a zero input do.
   function automatic flog_special_t special_decode(logic [DIM-1:0] fix, logic [6:0] special);
      flog_special_t r;
      r.hit   = 1'b1;
      r.value = PLUS_ZERO_BF16;
      if (special[SP_IS_QNAN] | special[SP_IS_SNAN] | special[SP_IS_NAN]) begin
         r.value = QNAN_BF16;
      end else if (special[SP_IS_POS_ZERO]) begin
         r.value = MINUS_INF_BF16;  // log2(+0) = -inf
      end else if (special[SP_IS_NEG]) begin
         r.value = QNAN_BF16;
      end else if (special[SP_IS_POS_INF]) begin
         r.value = PLUS_INF_BF16;
      end else if (fix == '0) begin
         r.value = PLUS_ZERO_BF16;
      end else begin
         r.hit = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/flog_rne.sv
// flog_rne: round-to-nearest-even of a normalised magnitude to a 7-bit bfloat16 mantissa.
//   mag     in  21  magnitude bits below the leading one
//   exp_in  in  8   exponent before rounding
//   exp_out out 8   exponent after rounding (incremented on mantissa overflow)
//   mant    out 7   rounded mantissa
module flog_rne (
   input  logic [20:0] mag,
   input  logic [7:0]  exp_in,
   output logic [7:0]  exp_out,
   output logic [6:0]  mant
);

   logic       guard;
   logic       sticky;
   logic       round_up;
   logic [7:0] mant_inc;

   assign guard    = mag[13];
   assign sticky   = |mag[12:0];
   assign round_up = guard & (sticky | mag[14]);
   assign mant_inc = {1'b0, mag[20:14]} + 8'd1;

   always_comb begin
      exp_out = exp_in;
      mant    = mag[20:14];
      if (round_up) begin
         mant    = mant_inc[6:0];
         exp_out = exp_in + {7'd0, mant_inc[7]};  // 0x7F + 1 wraps mantissa to 0
      end
   end

endmodule

// File: rtl/flog_i2f.sv
// flog_i2f: converts the signed fixed-point log2 result into bfloat16.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i/ready_o    operand handshake; ready_o only in IDLE
//   fix_i     in  22   two's-complement log2 value, 14 fractional bits
//   special_i in  7    {isNeg, isPosInf, isPosZero, isQNaN, isSNaN, isNaN, isOpValid}
//   valid_o/ready_i    result handshake; valid_o only in DONE
//   result_o  out 16   bfloat16 result, held stable while in DONE
// Normalisation shifts one bit per cycle until the leading one reaches the MSB.
module flog_i2f
   import flog_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [DIM-1:0] fix_i,
   input  logic [6:0]     special_i,
   output logic           valid_o,
   input  logic           ready_i,
   output logic [15:0]    result_o
);

   flog_i2f_state_t state_q, state_d;
   logic [DIM-1:0]  mag_q, mag_d;
   logic [4:0]      s_q, s_d;
   logic            sign_q, sign_d;
   logic [15:0]     result_q, result_d;

   flog_special_t   special;
   logic [7:0]      exp_pre;
   logic [7:0]      exp_rnd;
   logic [6:0]      mant_rnd;

   assign special = special_decode(fix_i, special_i);
   assign exp_pre = 8'(EXP_BASE) - {3'd0, s_q};

   flog_rne u_rne (
      .mag     (mag_q[DIM-2:0]),
      .exp_in  (exp_pre),
      .exp_out (exp_rnd),
      .mant    (mant_rnd)
   );

   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      s_d      = s_q;
      sign_d   = sign_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (special.hit) begin
                  result_d = special.value;
                  state_d  = DONE;
               end else begin
                  sign_d  = fix_i[DIM-1];
                  // -2^21 negates to 2^21, which still fits unsigned
                  mag_d   = fix_i[DIM-1] ? (~fix_i + 22'd1) : fix_i;
                  s_d     = '0;
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (mag_q[DIM-1]) begin
               state_d = ROUND;
            end else begin
               mag_d = {mag_q[DIM-2:0], 1'b0};
               s_d   = s_q + 5'd1;
            end
         end
         ROUND: begin
            result_d = {sign_q, exp_rnd, mant_rnd};
            state_d  = DONE;
         end
         DONE: begin
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         s_q      <= '0;
         sign_q   <= 1'b0;
         result_q <= PLUS_ZERO_BF16;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         s_q      <= s_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_flog_i2f.sv
// tb_flog_i2f: scoreboard bench for flog_i2f with directed and random operands.
module tb_flog_i2f;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic        ready_o;
   logic [21:0] fix_i;
   logic [6:0]  special_i;
   logic        valid_o;
   logic        ready_i;
   logic [15:0] result_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pushes = 0;
   int transfers = 0;

   logic [15:0] exp_q[$];
   int          lat_q[$];
   int          acc_q[$];

   flog_i2f dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .fix_i     (fix_i),
      .special_i (special_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .result_o  (result_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference: log2 value = fix/2^14; normalise via floor(log2|fix|), round with integer remainder.
   task automatic ref_model(input logic [21:0] f, input logic [6:0] sp,
                            output logic [15:0] res, output int lat);
      int v, m, p, k, q, rem, half, e;
      logic sgn;
      lat = 1;
      if (sp[3] | sp[2] | sp[1])      res = 16'h7FC0;
      else if (sp[4])                 res = 16'hFF80;
      else if (sp[6])                 res = 16'h7FC0;
      else if (sp[5])                 res = 16'h7F80;
      else if (f == 22'd0)            res = 16'h0000;
      else begin
         sgn = f[21];
         v = f[21] ? (int'(f) - (1 << 22)) : int'(f);
         m = sgn ? -v : v;
         p = 0;
         for (int i = 0; i < 23; i++) if ((m >> i) != 0) p = i;
         e = 127 + p - 14;
         if (p > 7) begin
            k = p - 7;
            q = m >> k;
            rem = m - (q << k);
            half = 1 << (k - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == 256) begin
               q = 128;
               e = e + 1;
            end
         end else begin
            q = m << (7 - p);
         end
         res = {sgn, 8'(e), 7'(q)};
         lat = (21 - p) + 3;
      end
   endtask

   // Monitor: pop and compare on the first valid cycle, check stability while stalled.
   initial begin : monitor
      bit          seen;
      logic [15:0] held;
      logic [15:0] er;
      int          el, ac;
      seen = 0;
      held = '0;
      forever begin
         @(posedge clk_i);
         if (!rst_ni) begin
            seen = 0;
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
         end else if (valid_o) begin
            if (!seen) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output got %h with nothing expected", result_o);
               end else begin
                  er = exp_q.pop_front();
                  el = lat_q.pop_front();
                  ac = acc_q.pop_front();
                  if (result_o !== er) begin
                     errors++;
                     $display("FAIL result got %h expected %h", result_o, er);
                  end
                  checks++;
                  if (cyc - ac != el) begin
                     errors++;
                     $display("FAIL latency got %0d expected %0d (result %h)", cyc - ac, el, er);
                  end
               end
               held = result_o;
               seen = 1;
            end else begin
               checks++;
               if (result_o !== held || ready_o !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_hold got result %h ready %b expected %h ready 0",
                           result_o, ready_o, held);
               end
            end
            if (ready_i) begin
               seen = 0;
               transfers++;
            end
         end
      end
   end

   task automatic run_op(input logic [21:0] f, input logic [6:0] sp, input int stall);
      logic [15:0] er;
      int          el;
      bit          ok;
      ref_model(f, sp, er, el);
      @(negedge clk_i);
      fix_i = f;
      special_i = sp;
      valid_i = 1'b1;
      ready_i = 1'b0;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(posedge clk_i);
         if (ready_o) begin
            ok = 1;
            exp_q.push_back(er);
            lat_q.push_back(el);
            acc_q.push_back(cyc);
            pushes++;
         end
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got ready_o 0 expected 1");
      end else begin
         ok = 0;
         for (int i = 0; i < 40 && !ok; i++) begin
            if (valid_o) ok = 1;
            else @(negedge clk_i);
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL result_timeout got valid_o 0 expected 1 for fix %h", f);
         end
         repeat (stall) @(negedge clk_i);
         ready_i = 1'b1;
         @(negedge clk_i);
         ready_i = 1'b0;
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got no finish expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int bad;
      rst_ni = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      fix_i = '0;
      special_i = '0;
      #12;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state got ready %b valid %b result %h expected 1 0 0000",
                  ready_o, valid_o, result_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Directed normal path and rounding
      run_op(22'h004000, 7'h01, 0);
      run_op(22'h3FC000, 7'h01, 0);
      run_op(22'h004040, 7'h01, 0);
      run_op(22'h0040C0, 7'h01, 1);
      run_op(22'h007FC0, 7'h01, 0);
      run_op(22'h1FFFFF, 7'h01, 0);
      run_op(22'h200000, 7'h01, 0);
      run_op(22'h000001, 7'h01, 0);
      // Specials
      run_op(22'h012345, 7'h11, 0);
      run_op(22'h012345, 7'h05, 0);
      run_op(22'h012345, 7'h41, 0);
      run_op(22'h012345, 7'h21, 0);
      run_op(22'h000000, 7'h01, 0);
      // Backpressure
      run_op(22'h004000, 7'h01, 5);

      // Reset mid-NORM
      @(negedge clk_i);
      fix_i = 22'h000001;
      special_i = 7'h01;
      valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_norm got valid %b ready %b expected 0 1", valid_o, ready_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      bad = 0;
      repeat (30) begin
         @(negedge clk_i);
         if (valid_o) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL post_reset_quiet got %0d valid cycles expected 0", bad);
      end
      run_op(22'h004000, 7'h01, 0);

      // Random operands
      for (int n = 0; n < 60; n++) begin
         logic [21:0] f;
         logic [6:0]  sp;
         f = 22'($urandom() >> $urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) f = -f;
         sp = ($urandom_range(0, 3) == 0) ? 7'($urandom()) : 7'h01;
         run_op(f, sp, $urandom_range(0, 3));
      end

      repeat (3) @(negedge clk_i);
      checks++;
      if (transfers != pushes || exp_q.size() != 0) begin
         errors++;
         $display("FAIL transfer_count got %0d transfers (%0d pending) expected %0d",
                  transfers, exp_q.size(), pushes);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
